// File: rtl/instr_fetch_pkg.sv
// Shared processor package: fetch-path widths, queue depth and the queue entry type.
package instr_fetch_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;
    localparam int QDEPTH = 2;
    localparam int LVL_W  = $clog2(QDEPTH + 1);

    localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(QDEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, execute-stage redirect and decoder handshake.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [PC_W-1:0]   rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              jump;
    logic [PC_W-1:0]   jump_target;
    logic              dec_ready;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic [LVL_W-1:0]  level;

    // Fetch block side
    modport master (
        output rom_addr, inst_valid, inst, inst_pc, level,
        input  rom_data, jump, jump_target, dec_ready
    );

    // ROM / execute / decoder side
    modport slave (
        input  rom_addr, inst_valid, inst, inst_pc, level,
        output rom_data, jump, jump_target, dec_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: 2-entry in-order register queue with push, pop, flush and level.
// Entry 0 is always the head, so the read side comes straight from registers.
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic             rd_valid,
    output logic [LVL_W-1:0] level
);

    fetch_entry_t e0;
    fetch_entry_t e1;

    // Queue storage and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= LVL_EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            level <= LVL_EMPTY;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (level == LVL_EMPTY) e0 <= wr_entry;
                    else                    e1 <= wr_entry;
                    level <= level + LVL_ONE;
                end
                2'b01: begin
                    e0    <= e1;
                    level <= level - LVL_ONE;
                end
                2'b11: begin
                    // Level unchanged; the new entry lands behind whatever remains.
                    if (level == LVL_ONE) begin
                        e0 <= wr_entry;
                    end else begin
                        e0 <= e1;
                        e1 <= wr_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = (level != LVL_EMPTY);
    assign rd_entry = rd_valid ? e0 : '0;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, ROM addressing and push/redirect control in front of a
// 2-entry instruction queue feeding the decoder.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    logic [PC_W-1:0] fetch_pc;
    logic            pop;
    logic            push;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    new_entry;
    logic [LVL_W-1:0] q_level;

    // A pop during a jump is the branch itself being consumed; the flush drops the rest.
    assign pop       = head_valid & bus.dec_ready;
    assign push      = ~bus.jump & ((q_level != LVL_FULL) | pop);
    assign new_entry = '{pc: fetch_pc, inst: bus.rom_data};

    // Fetch PC: redirect has priority, otherwise advance on every push (wraps mod 256).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
        end else if (bus.jump) begin
            fetch_pc <= bus.jump_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_W'(1);
        end
    end

    fetch_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (bus.jump),
        .wr_entry (new_entry),
        .rd_entry (head),
        .rd_valid (head_valid),
        .level    (q_level)
    );

    assign bus.rom_addr   = fetch_pc;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.level      = q_level;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch stage.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction ROM: ROM[n] = 16'h1000 + n
    assign bus.rom_data = 16'h1000 + {8'h00, bus.rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of fetched PCs and the next PC to fetch
    int mq[$];
    int mpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        v;
        logic [7:0]  hpc;
        logic [15:0] hin;
        v   = (mq.size() > 0);
        hpc = v ? 8'(mq[0]) : 8'h00;
        hin = v ? 16'h1000 + {8'h00, hpc} : 16'h0000;
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'(v));
        chk({tag, "_pc"},    32'(bus.inst_pc),    32'(hpc));
        chk({tag, "_inst"},  32'(bus.inst),       32'(hin));
        chk({tag, "_level"}, 32'(bus.level),      32'(mq.size()));
        chk({tag, "_addr"},  32'(bus.rom_addr),   32'(mpc));
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 0;
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, then check after the edge.
    task automatic cycle(input logic j, input logic [7:0] tgt, input logic rdy, input string tag);
        int  lvl;
        bit  popped;
        bus.jump        = j;
        bus.jump_target = tgt;
        bus.dec_ready   = rdy;
        lvl    = mq.size();
        popped = (lvl > 0) && rdy;
        if (j) begin
            mq.delete();
            mpc = tgt;
        end else begin
            if (popped) void'(mq.pop_front());
            if (lvl < 2 || popped) begin
                mq.push_back(mpc);
                mpc = (mpc + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bit found;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.jump = 1'b0;
        bus.jump_target = 8'hA5;
        bus.dec_ready = 1'b0;
        model_reset();

        // Reset state, before and across edges
        #2;
        check_all("rst0");
        @(posedge clk); #1;
        check_all("rst1");

        // Stream with decoder always ready
        reset = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'($urandom), 1'b1, "stream");
        chk("stream_pc7", 32'(bus.inst_pc), 32'h07);

        // Stall five cycles after reset, then drain in order
        reset = 1'b0;
        #2;
        model_reset();
        check_all("rst2");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'($urandom), 1'b0, "stall");
        chk("stall_level", 32'(bus.level), 32'd2);
        chk("stall_addr",  32'(bus.rom_addr), 32'h02);
        chk("stall_head",  32'(bus.inst_pc), 32'h00);
        cycle(1'b0, 8'h00, 1'b1, "drain");
        chk("drain_pc1",   32'(bus.inst_pc), 32'h01);
        chk("drain_lvl",   32'(bus.level), 32'd2);
        cycle(1'b0, 8'h00, 1'b1, "drain");
        chk("drain_pc2",   32'(bus.inst_pc), 32'h02);

        // Advance to head pc 5 with a full queue, then redirect
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.inst_pc == 8'h05 && bus.level == 2'd2) found = 1'b1;
            else cycle(1'b0, 8'($urandom), 1'b1, "seek5");
        end
        chk("seek5_found", 32'(found), 32'd1);
        cycle(1'b1, 8'h40, 1'b1, "jump");
        chk("jump_valid", 32'(bus.inst_valid), 32'd0);
        chk("jump_addr",  32'(bus.rom_addr), 32'h40);
        cycle(1'b0, 8'h99, 1'b1, "jump_next");
        chk("jump_pc40",  32'(bus.inst_pc), 32'h40);

        // PC wrap FF -> 00
        cycle(1'b1, 8'hFD, 1'b0, "wrapj");
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'($urandom), 1'b1, "wrap");
        chk("wrap_pc00", 32'(bus.inst_pc), 32'h00);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom), "rand");

        // Mid-stream asynchronous reset
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, "prefill");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("async_hold");
        #2;
        reset = 1'b1;
        cycle(1'b0, 8'h77, 1'b1, "after_rst");
        chk("after_rst_pc", 32'(bus.inst_pc), 32'h00);
        chk("after_rst_v",  32'(bus.inst_valid), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'($urandom), 1'($urandom), "tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-004 rom_addr  output  8  fetch address to the instruction ROM; equals the internal fetch PC.
REQ-005 rom_data  input  16  combinational ROM read data for rom_addr.
REQ-006 jump  input  1  taken-branch redirect from the execute stage (condition AND zero).
REQ-007 jump_target  input  8  redirect PC; valid when jump=1.
REQ-008 dec_ready  input  1  decoder accepts the head instruction this cycle.
REQ-009 inst_valid  output  1  head entry holds a valid instruction.
REQ-010 inst  output  16  head instruction to the decoder; 16'h0000 when inst_valid=0.
REQ-011 inst_pc  output  8  PC of the head instruction; 8'h00 when inst_valid=0.
REQ-012 level  output  2  current queue occupancy, 0..2.

Function
REQ-013 The block SHALL hold a 2-entry in-order queue of {pc, instruction} pairs with a registered head.
REQ-014 Pop: when inst_valid=1 and dec_ready=1, the head entry SHALL be removed at the clock edge.
REQ-015 Push: when jump=0 and (level<2 or a pop occurs), the block SHALL enqueue {fetch_pc, rom_data} and increment fetch_pc by 1 at the edge.
REQ-016 fetch_pc SHALL wrap modulo 256 (8'hFF -> 8'h00) with no flag.
REQ-017 Full: with level=2 and no pop, the block SHALL neither push nor change fetch_pc.
REQ-018 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-019 Redirect: when jump=1, the block SHALL, at the edge, flush every queue entry, set fetch_pc to jump_target, and suppress the push; jump has priority over push.
REQ-020 A pop in the same cycle as jump SHALL still count as consumed (the branch itself); no stale entry SHALL remain.
REQ-021 Latency: the first instruction after reset or redirect SHALL appear with inst_valid=1 one edge after it is fetched (two edges after the redirect edge).
REQ-022 inst_valid, inst, inst_pc and level SHALL be driven from registers only, with no combinational path from dec_ready or jump to outputs.
REQ-023 jump_target SHALL be ignored when jump=0.

Reset
REQ-024 While reset=0: fetch_pc=8'h00, queue empty, level=0, inst_valid=0, inst=16'h0000, inst_pc=8'h00.
REQ-025 An assertion of reset in mid-operation SHALL discard all queued and in-flight instructions; the first edge after release SHALL fetch address 8'h00.

Structure
REQ-026 PC_W=8, INST_W=16 and QDEPTH=2 SHALL be defined in the shared processor package and used by this block.
REQ-027 The queue SHALL be a sub-module fetch_fifo (2-entry register FIFO with push, pop, flush, level); the PC register and push/redirect control SHALL reside in instr_fetch.

Verification
REQ-028 Reset release, ROM[n]=16'h1000+n, dec_ready=1 -> inst_pc 0,1,2,... on consecutive cycles; first inst_valid one edge after release.
REQ-029 dec_ready=0 for 5 cycles -> level rises to 2, rom_addr holds at 8'h02; on dec_ready=1 -> inst_pc 0,1,2 in order with no gap or duplicate.
REQ-030 jump=1, jump_target=8'h40 at inst_pc=8'h05 with level=2 -> queue flushed, inst_valid=0 for one cycle, next inst_pc=8'h40.
REQ-031 fetch_pc reaches 8'hFF with dec_ready=1 -> the following inst_pc is 8'h00.
REQ-032 Full queue with push and pop in the same cycle -> level stays 2, order preserved.
REQ-033 reset=0 asserted mid-stream between edges -> outputs clear immediately; after release the first inst_pc is 8'h00.
